// File: rtl/program_store_if.sv
// Fetch and program-load bus for program_store.
// master: control unit / loader side; slave: the store.
interface program_store_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int BANKS  = 2
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [BANK_W-1:0] bank_sel;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              ready;

    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_err;

    modport master (
        output bank_sel, fetch_en, fetch_addr,
        output wr_en, wr_bank, wr_addr, wr_data,
        input  instr_out, instr_valid, ready,
        input  wr_ack, wr_err
    );

    modport slave (
        input  bank_sel, fetch_en, fetch_addr,
        input  wr_en, wr_bank, wr_addr, wr_data,
        output instr_out, instr_valid, ready,
        output wr_ack, wr_err
    );
endinterface

// File: rtl/program_store.sv
// Writable multi-bank program store with NOP init sweep after reset.
// Ports: clk, rst_n (async active-low), bus (program_store_if.slave):
//   fetch side  bank_sel/fetch_en/fetch_addr -> instr_out/instr_valid, ready
//   load side   wr_en/wr_bank/wr_addr/wr_data -> wr_ack/wr_err pulses
module program_store #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int BANKS  = 2,
    parameter logic [DATA_W-1:0] NOP_OP = DATA_W'(4'b0111)
) (
    input  logic clk,
    input  logic rst_n,
    program_store_if.slave bus
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [BANK_W:0] BANKS_L = (BANK_W+1)'(BANKS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH-1);

    typedef enum logic [1:0] {
        INIT = 2'b01,
        RUN  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [BANKS][DEPTH];

    logic              sweep;
    logic              mem_we;
    logic              fetch_ok;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_word;

    assign fetch_ok = ({1'b0, bus.fetch_addr} < DEPTH_L)
                   && ({1'b0, bus.bank_sel} < BANKS_L);
    assign wr_ok    = ({1'b0, bus.wr_addr} < DEPTH_L)
                   && ({1'b0, bus.wr_bank} < BANKS_L);

    // Out-of-range fetches read as NOP rather than an error.
    assign rd_word = fetch_ok
                   ? mem_q[bus.bank_sel][bus.fetch_addr]
                   : NOP_OP;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        sweep   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            INIT: begin
                sweep = 1'b1;
                err_d = bus.wr_en;
                if (ptr_q == LAST) begin
                    ptr_d   = '0;
                    state_d = RUN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            RUN: begin
                if (bus.fetch_en) begin
                    valid_d = 1'b1;
                    instr_d = rd_word;
                end
                if (bus.wr_en) begin
                    mem_we = wr_ok;
                    ack_d  = wr_ok;
                    err_d  = !wr_ok;
                end
            end
            default: begin
                state_d = INIT;
                ptr_d   = '0;
            end
        endcase
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
            instr_q <= NOP_OP;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Storage carries no reset; the sweep defines its contents.
    // Reads above use the pre-edge contents, giving read-first.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (sweep) begin
                mem_q[b][ptr_q] <= NOP_OP;
            end else if (mem_we && bus.wr_bank == BANK_W'(b)) begin
                mem_q[b][bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.ready       = ready_q;
    assign bus.wr_ack      = ack_q;
    assign bus.wr_err      = err_q;
endmodule

// File: tb/tb_program_store.sv
// Self-checking bench for program_store: two instances
// (16x2 banks and 12x3 banks) driven by directed steps.
module tb_program_store;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    program_store_if #(.DATA_W(4), .ADDR_W(4), .BANKS(2)) bus0 ();
    program_store_if #(.DATA_W(4), .ADDR_W(4), .BANKS(3)) bus1 ();

    program_store #(
        .DATA_W(4), .ADDR_W(4), .DEPTH(16), .BANKS(2)
    ) u0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    program_store #(
        .DATA_W(4), .ADDR_W(4), .DEPTH(12), .BANKS(3)
    ) u1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    localparam logic [3:0] NOP = 4'b0111;

    typedef struct {
        string      tag;
        int         d;
        logic [3:0] instr;
        logic       valid;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m[2][4][16];
    logic [3:0] last[2];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus0.fetch_en = 1'b0; bus0.bank_sel = '0; bus0.fetch_addr = '0;
        bus0.wr_en = 1'b0; bus0.wr_bank = '0; bus0.wr_addr = '0;
        bus0.wr_data = '0;
        bus1.fetch_en = 1'b0; bus1.bank_sel = '0; bus1.fetch_addr = '0;
        bus1.wr_en = 1'b0; bus1.wr_bank = '0; bus1.wr_addr = '0;
        bus1.wr_data = '0;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            last[d] = NOP;
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 16; a++)
                    m[d][b][a] = NOP;
        end
    endtask

    // One directed step on instance d; expectation comes from the model.
    task automatic cyc(input int d, input logic fe, input logic [1:0] bs,
                       input logic [3:0] fa, input logic we,
                       input logic [1:0] wb, input logic [3:0] wa,
                       input logic [3:0] wd, input string tag);
        exp_t e;
        int depth, banks;
        logic [3:0] ri;
        logic rv, ra, re, rr;
        depth = (d == 0) ? 16 : 12;
        banks = (d == 0) ? 2 : 3;
        e.tag = tag;
        e.d = d;
        e.valid = fe;
        if (fe) begin
            e.instr = (int'(fa) < depth && int'(bs) < banks)
                    ? m[d][bs][fa] : NOP;
            last[d] = e.instr;
        end else begin
            e.instr = last[d];
        end
        e.ack = we && int'(wa) < depth && int'(wb) < banks;
        e.err = we && !e.ack;
        idle();
        if (d == 0) begin
            bus0.fetch_en = fe; bus0.bank_sel = bs[0]; bus0.fetch_addr = fa;
            bus0.wr_en = we; bus0.wr_bank = wb[0]; bus0.wr_addr = wa;
            bus0.wr_data = wd;
        end else begin
            bus1.fetch_en = fe; bus1.bank_sel = bs; bus1.fetch_addr = fa;
            bus1.wr_en = we; bus1.wr_bank = wb; bus1.wr_addr = wa;
            bus1.wr_data = wd;
        end
        sb.push_back(e);
        if (e.ack) m[d][wb][wa] = wd;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.d == 0) begin
            ri = bus0.instr_out; rv = bus0.instr_valid;
            ra = bus0.wr_ack; re = bus0.wr_err; rr = bus0.ready;
        end else begin
            ri = bus1.instr_out; rv = bus1.instr_valid;
            ra = bus1.wr_ack; re = bus1.wr_err; rr = bus1.ready;
        end
        chk({e.tag, ".instr"}, ri, e.instr);
        chk({e.tag, ".valid"}, {3'b0, rv}, {3'b0, e.valid});
        chk({e.tag, ".ack"}, {3'b0, ra}, {3'b0, e.ack});
        chk({e.tag, ".err"}, {3'b0, re}, {3'b0, e.err});
        chk({e.tag, ".ready"}, {3'b0, rr}, 4'd1);
    endtask

    // Sweep after rst_n release: fetches ignored, write at edge 3 rejected.
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 16; i++) begin
            idle();
            bus0.fetch_en = 1'b1;
            bus0.fetch_addr = 4'd5;
            bus0.wr_en = (i == 3);
            bus0.wr_addr = 4'd1;
            bus0.wr_data = 4'b1111;
            bus1.wr_en = (i == 3);
            bus1.wr_addr = 4'd1;
            @(posedge clk);
            #1;
            chk($sformatf("%s.rdy0.e%0d", tag, i), {3'b0, bus0.ready},
                {3'b0, i >= 16});
            chk($sformatf("%s.rdy1.e%0d", tag, i), {3'b0, bus1.ready},
                {3'b0, i >= 12});
            chk($sformatf("%s.val0.e%0d", tag, i),
                {3'b0, bus0.instr_valid}, 4'd0);
            chk($sformatf("%s.ins0.e%0d", tag, i), bus0.instr_out, NOP);
            chk($sformatf("%s.err0.e%0d", tag, i), {3'b0, bus0.wr_err},
                {3'b0, i == 3});
            chk($sformatf("%s.ack0.e%0d", tag, i), {3'b0, bus0.wr_ack},
                4'd0);
            chk($sformatf("%s.err1.e%0d", tag, i), {3'b0, bus1.wr_err},
                {3'b0, i == 3});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        clear_model();
        #1 rst_n = 1'b0;
        #1;
        chk("rst.instr", bus0.instr_out, NOP);
        chk("rst.valid", {3'b0, bus0.instr_valid}, 4'd0);
        chk("rst.ready", {3'b0, bus0.ready}, 4'd0);
        chk("rst.ack", {3'b0, bus0.wr_ack}, 4'd0);
        chk("rst.err", {3'b0, bus0.wr_err}, 4'd0);
        chk("rst.ready1", {3'b0, bus1.ready}, 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check("init");

        cyc(0, 1, 2'd0, 4'd5, 0, 2'd0, 4'd0, 4'd0, "nop_b0");
        cyc(0, 1, 2'd1, 4'd5, 0, 2'd0, 4'd0, 4'd0, "nop_b1");

        cyc(0, 0, 2'd0, 4'd0, 1, 2'd0, 4'd0, 4'b0000, "ld0");
        cyc(0, 0, 2'd0, 4'd0, 1, 2'd0, 4'd1, 4'b0001, "ld1");
        cyc(0, 0, 2'd0, 4'd0, 1, 2'd0, 4'd2, 4'b1010, "ld2");
        cyc(0, 0, 2'd0, 4'd0, 1, 2'd0, 4'd3, 4'b0010, "ld3");
        for (int a = 0; a < 4; a++)
            cyc(0, 1, 2'd0, 4'(a), 0, 2'd0, 4'd0, 4'd0,
                $sformatf("fetch%0d", a));
        cyc(0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0, 4'd0, "hold");

        cyc(0, 0, 2'd0, 4'd0, 1, 2'd1, 4'd2, 4'b1011, "ld_b1");
        cyc(0, 1, 2'd0, 4'd2, 0, 2'd0, 4'd0, 4'd0, "iso_b0a");
        cyc(0, 1, 2'd1, 4'd2, 0, 2'd0, 4'd0, 4'd0, "iso_b1");
        cyc(0, 1, 2'd0, 4'd2, 0, 2'd0, 4'd0, 4'd0, "iso_b0b");

        cyc(0, 0, 2'd0, 4'd0, 1, 2'd1, 4'd15, 4'b1100, "ld_top");
        cyc(0, 1, 2'd1, 4'd15, 0, 2'd0, 4'd0, 4'd0, "f_top");

        cyc(0, 0, 2'd0, 4'd0, 1, 2'd0, 4'd4, 4'b0110, "ld4");
        cyc(0, 1, 2'd0, 4'd4, 1, 2'd0, 4'd4, 4'b1110, "coll_old");
        cyc(0, 1, 2'd0, 4'd4, 0, 2'd0, 4'd0, 4'd0, "coll_new");

        cyc(1, 0, 2'd0, 4'd0, 1, 2'd0, 4'd13, 4'b1001, "w_addr13");
        cyc(1, 0, 2'd0, 4'd0, 1, 2'd2, 4'd11, 4'b0101, "w_b2a11");
        cyc(1, 1, 2'd0, 4'd13, 0, 2'd0, 4'd0, 4'd0, "f_addr13");
        cyc(1, 0, 2'd0, 4'd0, 1, 2'd3, 4'd1, 4'b1001, "w_bank3");
        cyc(1, 1, 2'd3, 4'd1, 0, 2'd0, 4'd0, 4'd0, "f_bank3");
        cyc(1, 1, 2'd2, 4'd11, 0, 2'd0, 4'd0, 4'd0, "f_b2a11");
        cyc(1, 1, 2'd0, 4'd11, 0, 2'd0, 4'd0, 4'd0, "f_b0a11");
        cyc(1, 1, 2'd0, 4'd12, 0, 2'd0, 4'd0, 4'd0, "f_addr12");

        cyc(0, 1, 2'd0, 4'd1, 0, 2'd0, 4'd0, 4'd0, "pre_rst1");
        cyc(0, 1, 2'd0, 4'd2, 0, 2'd0, 4'd0, 4'd0, "pre_rst2");
        bus0.fetch_en = 1'b1;
        bus0.fetch_addr = 4'd3;
        rst_n = 1'b0;
        #1;
        chk("mid.valid", {3'b0, bus0.instr_valid}, 4'd0);
        chk("mid.ready", {3'b0, bus0.ready}, 4'd0);
        chk("mid.instr", bus0.instr_out, NOP);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        sweep_check("resweep");
        cyc(0, 1, 2'd0, 4'd0, 0, 2'd0, 4'd0, 4'd0, "post_a0");
        cyc(0, 1, 2'd1, 4'd2, 0, 2'd0, 4'd0, 4'd0, "post_b1a2");
        cyc(1, 1, 2'd2, 4'd11, 0, 2'd0, 4'd0, 4'd0, "post_u1");

        idle();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
